booth_mac: RTL and testbench

Sequential multiply-accumulate stage wrapped around the team's combinational 8x8 signed Booth array multiplier (`booth`). It accepts a stream of signed 8-bit operand pairs over a valid/ready handshake and registers each 16-bit product. It sums `LEN` consecutive products into a signed accumulator and presents the dot-product result on a valid/ready output port. It is the clocked front end and back end that turns the purely combinational multiplier into a pipelined MAC for filter and dot-product datapaths.

---
 rtl/booth_mac.sv | 165 ++++++++++++++++
 tb/tb_booth_mac.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac.sv
// Pipelined signed 8x8 MAC: S1 operand regs, Booth product into S2, S3 accumulator; result valid 2 edges after last term.
// in_ready from FSM state only (ACC); result held while out_valid && !out_ready. BOOTH_MAC_SAT_EN selects saturating accumulate.

module booth (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);
  logic        [8:0]  ax;
  logic signed [15:0] bx;
  logic signed [15:0] pp;
  logic signed [15:0] sum;
  logic        [2:0]  grp;

  assign ax = {a, 1'b0};
  assign bx = 16'(b);

  // Radix-4 recoding of a: four digits in {-2,-1,0,1,2}, each weighted by 4^i.
  always_comb begin
    sum = '0;
    pp  = '0;
    grp = '0;
    for (int i = 0; i < 4; i++) begin
      grp = ax[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = bx;
        3'b011:         pp = bx <<< 1;
        3'b100:         pp = -(bx <<< 1);
        3'b101, 3'b110: pp = -bx;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2*i));
    end
  end

  assign p = sum;
endmodule

module booth_mac #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_OUT} state_t;

  state_t                  state, state_nxt;
  logic signed [7:0]       a_q, b_q;
  logic                    v1, v2;
  logic signed [15:0]      prod, p_q;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic        [CNT_W-1:0] cnt;
  logic                    accept, cnt_last, drain;

  assign accept   = in_valid && (state == ST_ACC);
  assign cnt_last = (cnt == CNT_W'(LEN - 1));
  assign drain    = (state == ST_OUT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // FLUSH exits once S1 is empty: any product still in S2 lands in acc on that same edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!v1) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  booth u_booth (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) p_q <= prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (drain)  cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  end

`ifdef BOOTH_MAC_SAT_EN
  logic signed [ACC_W:0] sum_w;
  logic                  ovf, ovf_nxt;

  always_comb begin
    sum_w   = (ACC_W+1)'(acc) + (ACC_W+1)'(p_q);
    acc_nxt = sum_w[ACC_W-1:0];
    ovf_nxt = ovf;
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      ovf_nxt = 1'b1;
      acc_nxt = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ovf <= 1'b0;
    else if (drain) ovf <= 1'b0;
    else if (v2)    ovf <= ovf_nxt;
  end

  assign out_ovf = ovf;
`else
  assign acc_nxt = acc + ACC_W'(p_q);
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (drain) acc <= '0;
    else if (v2)    acc <= acc_nxt;
  end

  assign out_data = acc;
endmodule

// File: tb/tb_booth_mac.sv
// Bench for booth_mac: three instances (LEN=4/ACC_W=24, LEN=1/ACC_W=24, LEN=4/ACC_W=16) against a dot-product model.
// Honours BOOTH_MAC_SAT_EN when building expected values.
module tb_booth_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              iv[3], ir[3], ov[3], ordy[3], ovf[3];
  logic signed [7:0] ia[3], ib[3];
  logic [23:0]       d0, d1;
  logic [15:0]       d2;

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qb[$];

`ifdef BOOTH_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  booth_mac #(.ACC_W(24), .LEN(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(d0), .out_ovf(ovf[0]));
  booth_mac #(.ACC_W(24), .LEN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(d1), .out_ovf(ovf[1]));
  booth_mac #(.ACC_W(16), .LEN(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(d2), .out_ovf(ovf[2]));

  function automatic longint data_of(input int idx);
    case (idx)
      0:       return longint'($signed(d0));
      1:       return longint'($signed(d1));
      default: return longint'($signed(d2));
    endcase
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Dot product of the queued pairs, clamped per term when saturating, else reduced mod 2^accw.
  function automatic void model(input int accw, output longint res, output longint of);
    longint hi, lo, s, m;
    hi = (longint'(1) <<< (accw - 1)) - 1;
    lo = -hi - 1;
    m  = longint'(1) <<< accw;
    s  = 0;
    of = 0;
    foreach (qa[i]) begin
      s += longint'(qa[i]) * longint'(qb[i]);
      if (SAT) begin
        if (s > hi) begin s = hi; of = 1; end
        else if (s < lo) begin s = lo; of = 1; end
      end
    end
    if (!SAT) begin
      s = s & (m - 1);
      if (s > hi) s -= m;
    end
    res = s;
  endfunction

  task automatic run(input int idx, input int accw, input int maxgap, input int hold, input bit abort);
    longint er, eo;
    int g;
    model(accw, er, eo);
    for (int i = 0; i < qa.size(); i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        iv[idx] = 1'b0;
        ia[idx] = 8'($urandom);
        ib[idx] = 8'($urandom);
      end
      @(negedge clk);
      iv[idx] = 1'b1;
      ia[idx] = 8'(qa[i]);
      ib[idx] = 8'(qb[i]);
      check("in_ready_acc", longint'(ir[idx]), 1);
      @(posedge clk);
    end
    @(negedge clk);
    iv[idx] = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      #1;
      check("rst_in_ready", longint'(ir[idx]), 1);
      check("rst_out_valid", longint'(ov[idx]), 0);
      check("rst_out_data", data_of(idx), 0);
      check("rst_out_ovf", longint'(ovf[idx]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", longint'(ir[idx]), 1);
      check("post_rst_out_valid", longint'(ov[idx]), 0);
      return;
    end
    check("valid_n1", longint'(ov[idx]), 0);
    check("in_ready_flush", longint'(ir[idx]), 0);
    @(negedge clk);
    check("valid_n2", longint'(ov[idx]), 0);
    @(negedge clk);
    check("valid_n3", longint'(ov[idx]), 1);
    check("out_data", data_of(idx), er);
    check("out_ovf", longint'(ovf[idx]), eo);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", longint'(ov[idx]), 1);
      check("hold_data", data_of(idx), er);
      check("hold_in_ready", longint'(ir[idx]), 0);
    end
    ordy[idx] = 1'b1;
    @(negedge clk);
    ordy[idx] = 1'b0;
    check("post_hs_valid", longint'(ov[idx]), 0);
    check("post_hs_in_ready", longint'(ir[idx]), 1);
    check("post_hs_data", data_of(idx), 0);
  endtask

  task automatic fill_rand(input int n);
    qa = {};
    qb = {};
    for (int i = 0; i < n; i++) begin
      qa.push_back(int'($urandom_range(255, 0)) - 128);
      qb.push_back(int'($urandom_range(255, 0)) - 128);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ia[k] = '0; ib[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", longint'(ir[k]), 1);
      check("reset_out_valid", longint'(ov[k]), 0);
      check("reset_out_data", data_of(k), 0);
      check("reset_out_ovf", longint'(ovf[k]), 0);
    end

    qa = '{3, -5, 7, -2}; qb = '{4, 6, -8, -9};
    run(0, 24, 0, 0, 1'b0);
    check("dot4_const", data_of(0), 0);

    qa = '{-128}; qb = '{-128};
    run(1, 24, 0, 0, 1'b0);
    qa = '{-128}; qb = '{127};
    run(1, 24, 0, 0, 1'b0);

    qa = '{3, -5, 7, -2}; qb = '{4, 6, -8, -9};
    run(0, 24, 0, 5, 1'b0);
    qa = '{1, 1, 1, 1}; qb = '{1, 1, 1, 1};
    run(0, 24, 0, 0, 1'b0);

    qa = '{3, -5, 7, -2}; qb = '{4, 6, -8, -9};
    run(0, 24, 3, 0, 1'b0);

    qa = '{-128, -128, -128, -128}; qb = '{-128, -128, -128, -128};
    run(2, 16, 0, 0, 1'b0);

    qa = '{3, -5, 7, -2}; qb = '{4, 6, -8, -9};
    run(0, 24, 0, 0, 1'b1);
    qa = '{2, 2, 2, 2}; qb = '{3, 3, 3, 3};
    run(0, 24, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      fill_rand(4);
      run(0, 24, 2, int'($urandom_range(2, 0)), 1'b0);
    end
    for (int r = 0; r < 5; r++) begin
      fill_rand(1);
      run(1, 24, 1, 0, 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      fill_rand(4);
      run(2, 16, 2, int'($urandom_range(1, 0)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
